mxv_row_sequencer: RTL and testbench

Control sequencer for the matrix-vector dot-product datapath. On start, it walks every row of the matrix in NO_OF_UNITS-wide chunks and issues matrix and vector memory reads. It frames the chunks into the dot-product engine with valid/last, waits for each row's scalar result, and writes that result into the AP memory at the row index. It sits between the matrix/vector/AP memories and the dot-product engine and replaces ad-hoc per-chunk write-enable pulsing.

---
 rtl/mxv_row_sequencer_pkg.sv | 32 +++
 rtl/mxv_addr_gen.sv | 60 ++++++
 rtl/mxv_row_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_mxv_row_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_row_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mxv_row_sequencer_pkg
// Shared definitions for the matrix-vector row sequencer and its address
// generator: FSM state encoding, the log2 helper used to turn the chunk width
// into a shift amount, and the default datapath sizes shared with the
// dot-product engine.
// -----------------------------------------------------------------------------
package mxv_row_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        FIN      = 2'd3
    } seq_state_t;

    localparam int DEFAULT_ELEMENT_WIDTH = 32;
    localparam int DEFAULT_NO_OF_UNITS   = 8;

    // Ceiling log2; exact for the power-of-two chunk widths used here.
    function automatic int log2_units(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mxv_addr_gen.sv
// -----------------------------------------------------------------------------
// mxv_addr_gen
// Row/chunk counters for the matrix-vector sequencer.
//   clk, reset      : clock, synchronous active-high reset
//   clear           : zero all counters (accepted start)
//   chunk_step      : a chunk read was issued this cycle
//   row_step        : the current row's result was captured this cycle
//   chunks          : latched chunks per row
//   total_rows      : latched row count
//   mat_rd_addr     : row*chunks + chunk, truncated to ADDR_WIDTH
//   vec_rd_addr     : chunk, truncated to ADDR_WIDTH
//   row_addr        : current row, truncated to ADDR_WIDTH
//   chunk_last      : current chunk is the final one of the row
//   row_last        : current row is the final row
// -----------------------------------------------------------------------------
module mxv_addr_gen #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  chunk_step,
    input  logic                  row_step,
    input  logic [31:0]           chunks,
    input  logic [31:0]           total_rows,
    output logic [ADDR_WIDTH-1:0] mat_rd_addr,
    output logic [ADDR_WIDTH-1:0] vec_rd_addr,
    output logic [ADDR_WIDTH-1:0] row_addr,
    output logic                  chunk_last,
    output logic                  row_last
);

    logic [31:0]           chunk;
    logic [31:0]           row;
    // Running row*chunks, kept modulo 2^ADDR_WIDTH so no multiplier is needed.
    logic [ADDR_WIDTH-1:0] row_base;

    assign chunk_last  = (chunk == chunks - 32'd1);
    assign row_last    = (row + 32'd1 == total_rows);
    assign vec_rd_addr = chunk[ADDR_WIDTH-1:0];
    assign mat_rd_addr = row_base + chunk[ADDR_WIDTH-1:0];
    assign row_addr    = row[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            chunk    <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            if (chunk_step) begin
                chunk <= chunk_last ? 32'd0 : chunk + 32'd1;
            end
            if (row_step) begin
                row      <= row + 32'd1;
                row_base <= row_base + chunks[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mxv_row_sequencer.sv
// -----------------------------------------------------------------------------
// mxv_row_sequencer
// Walks every matrix row in NO_OF_UNITS-wide chunks, issues matrix/vector
// memory reads, frames the returning data into the dot-product engine with
// valid/last, waits for each row's result and writes it to the AP memory.
//   clk, reset                 : clock, synchronous active-high reset
//   start, total_cols/rows     : pass request and its dimensions
//   busy, done                 : pass status, done is a one-cycle pulse
//   mat_rd_*, vec_rd_*         : memory read strobes and chunk addresses
//   dp_ready                   : engine accepts a chunk next cycle
//   dp_in_valid, dp_in_last    : framing of read data into the engine
//   dp_result_valid, dp_result : per-row engine result
//   ap_we, ap_addr, ap_data    : AP memory write port
// Optional build macro MXV_SEQ_PERF_EN adds perf_cycles (busy cycles) and
// perf_stalls (ISSUE cycles with dp_ready low).
// -----------------------------------------------------------------------------
module mxv_row_sequencer
    import mxv_row_sequencer_pkg::*;
#(
    parameter int NO_OF_UNITS   = DEFAULT_NO_OF_UNITS,
    parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              total_cols,
    input  logic [31:0]              total_rows,
    output logic                     busy,
    output logic                     done,
    output logic                     mat_rd_en,
    output logic [ADDR_WIDTH-1:0]    mat_rd_addr,
    output logic                     vec_rd_en,
    output logic [ADDR_WIDTH-1:0]    vec_rd_addr,
    input  logic                     dp_ready,
    output logic                     dp_in_valid,
    output logic                     dp_in_last,
    input  logic                     dp_result_valid,
    input  logic [ELEMENT_WIDTH-1:0] dp_result,
    output logic                     ap_we,
    output logic [ADDR_WIDTH-1:0]    ap_addr,
    output logic [ELEMENT_WIDTH-1:0] ap_data
`ifdef MXV_SEQ_PERF_EN
    ,
    output logic [31:0]              perf_cycles,
    output logic [31:0]              perf_stalls
`endif
);

    localparam int CHUNK_SHIFT = log2_units(NO_OF_UNITS);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [31:0]           chunks;
    logic [31:0]           rows_total;
    logic [32:0]           cols_round;
    logic [31:0]           chunks_calc;
    logic                  start_accept;
    logic                  capture;
    logic                  chunk_last;
    logic                  row_last;
    logic [ADDR_WIDTH-1:0] row_addr;

    // Extra bit keeps the round-up from wrapping for very large column counts.
    assign cols_round  = {1'b0, total_cols} + 33'(NO_OF_UNITS - 1);
    assign chunks_calc = 32'(cols_round >> CHUNK_SHIFT);

    mxv_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_accept),
        .chunk_step  (mat_rd_en),
        .row_step    (capture),
        .chunks      (chunks),
        .total_rows  (rows_total),
        .mat_rd_addr (mat_rd_addr),
        .vec_rd_addr (vec_rd_addr),
        .row_addr    (row_addr),
        .chunk_last  (chunk_last),
        .row_last    (row_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (total_rows == 32'd0 || total_cols == 32'd0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (dp_ready && chunk_last) begin
                    state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (dp_result_valid) begin
                    state_next = row_last ? FIN : ISSUE;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        mat_rd_en    = 1'b0;
        vec_rd_en    = 1'b0;
        start_accept = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: start_accept = start;
            ISSUE: begin
                busy      = 1'b1;
                mat_rd_en = dp_ready;
                vec_rd_en = dp_ready;
            end
            WAIT_RES: begin
                busy    = 1'b1;
                capture = dp_result_valid;
            end
            FIN:     busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chunks     <= '0;
            rows_total <= '0;
        end else if (start_accept) begin
            chunks     <= chunks_calc;
            rows_total <= total_rows;
        end
    end

    // Memory data arrives one cycle after the read, so framing follows the
    // read strobe by one register; AP writes and done are registered too.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_in_valid <= 1'b0;
            dp_in_last  <= 1'b0;
            ap_we       <= 1'b0;
            ap_addr     <= '0;
            ap_data     <= '0;
            done        <= 1'b0;
        end else begin
            dp_in_valid <= mat_rd_en;
            dp_in_last  <= mat_rd_en & chunk_last;
            ap_we       <= capture;
            done        <= (state == FIN);
            if (capture) begin
                ap_addr <= row_addr;
                ap_data <= dp_result;
            end
        end
    end

`ifdef MXV_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (state == ISSUE && !dp_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mxv_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mxv_row_sequencer
// Scoreboard bench for mxv_row_sequencer: expected reads, last flags and AP
// writes are queued when a pass is launched and popped as the DUT produces
// them. A small engine model answers each row 3 cycles after its last chunk.
// -----------------------------------------------------------------------------
module tb_mxv_row_sequencer;

    localparam int NO_OF_UNITS   = 8;
    localparam int ELEMENT_WIDTH = 32;
    localparam int ADDR_WIDTH    = 16;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [31:0]              total_cols;
    logic [31:0]              total_rows;
    logic                     busy;
    logic                     done;
    logic                     mat_rd_en;
    logic [ADDR_WIDTH-1:0]    mat_rd_addr;
    logic                     vec_rd_en;
    logic [ADDR_WIDTH-1:0]    vec_rd_addr;
    logic                     dp_ready;
    logic                     dp_in_valid;
    logic                     dp_in_last;
    logic                     dp_result_valid;
    logic [ELEMENT_WIDTH-1:0] dp_result;
    logic                     ap_we;
    logic [ADDR_WIDTH-1:0]    ap_addr;
    logic [ELEMENT_WIDTH-1:0] ap_data;
`ifdef MXV_SEQ_PERF_EN
    logic [31:0]              perf_cycles;
    logic [31:0]              perf_stalls;
`endif

    mxv_row_sequencer #(
        .NO_OF_UNITS   (NO_OF_UNITS),
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .total_cols      (total_cols),
        .total_rows      (total_rows),
        .busy            (busy),
        .done            (done),
        .mat_rd_en       (mat_rd_en),
        .mat_rd_addr     (mat_rd_addr),
        .vec_rd_en       (vec_rd_en),
        .vec_rd_addr     (vec_rd_addr),
        .dp_ready        (dp_ready),
        .dp_in_valid     (dp_in_valid),
        .dp_in_last      (dp_in_last),
        .dp_result_valid (dp_result_valid),
        .dp_result       (dp_result),
        .ap_we           (ap_we),
        .ap_addr         (ap_addr),
        .ap_data         (ap_data)
`ifdef MXV_SEQ_PERF_EN
        ,
        .perf_cycles     (perf_cycles),
        .perf_stalls     (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_mat[$];
    logic [31:0] exp_vec[$];
    logic        exp_last[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    int          done_cnt    = 0;
    int          busy_cnt    = 0;
    int          rd_seen     = 0;
    int          eng_row     = 0;
    int          res_cnt     = 0;
    int          stall_after = -1;
    int          stall_left  = 0;
    logic [31:0] pass_tag    = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input int r, input logic [31:0] tag);
        return 32'h1000_0000 ^ (32'(r) * 32'h0101_0101) ^ tag;
    endfunction

    // Monitor plus engine/ready model, all on the falling edge so observation
    // happens before the inputs for the next rising edge are updated.
    initial begin
        forever begin
            @(negedge clk);
            if (mat_rd_en) begin
                rd_seen++;
                check_val("vec_en", 32'(vec_rd_en), 32'd1);
                if (exp_mat.size() > 0) begin
                    check_val("mat_addr", 32'(mat_rd_addr), exp_mat.pop_front());
                    check_val("vec_addr", 32'(vec_rd_addr), exp_vec.pop_front());
                end else begin
                    check_val("rd_extra", 32'(mat_rd_en), 32'd0);
                end
            end
            if (dp_in_valid) begin
                if (exp_last.size() > 0) begin
                    check_val("dp_last", 32'(dp_in_last), 32'(exp_last.pop_front()));
                end else begin
                    check_val("valid_extra", 32'(dp_in_valid), 32'd0);
                end
            end else if (dp_in_last) begin
                check_val("last_no_valid", 32'(dp_in_last), 32'd0);
            end
            if (ap_we) begin
                if (exp_wa.size() > 0) begin
                    check_val("ap_addr", 32'(ap_addr), exp_wa.pop_front());
                    check_val("ap_data", ap_data, exp_wd.pop_front());
                end else begin
                    check_val("wr_extra", 32'(ap_we), 32'd0);
                end
            end
            if (done) begin
                done_cnt++;
                check_val("done_after_wr", 32'(exp_wa.size()), 32'd0);
                check_val("done_busy", 32'(busy), 32'd0);
            end
            if (busy) busy_cnt++;
            if (!dp_ready) check_val("stall_rd", 32'(mat_rd_en), 32'd0);

            if (res_cnt > 0) begin
                res_cnt--;
                if (res_cnt == 0) begin
                    dp_result_valid = 1'b1;
                    dp_result       = model_result(eng_row, pass_tag);
                    eng_row++;
                end else begin
                    dp_result_valid = 1'b0;
                end
            end else begin
                dp_result_valid = 1'b0;
                dp_result       = $urandom;
            end
            if (dp_in_valid && dp_in_last) res_cnt = 3;

            if (stall_after >= 0 && rd_seen == stall_after && stall_left > 0) begin
                dp_ready = 1'b0;
                stall_left--;
            end else begin
                dp_ready = 1'b1;
            end
        end
    end

    task automatic setup_pass(input int cols, input int rows, input int stall_at);
        @(posedge clk);
        #2;
        pass_tag    = $urandom;
        eng_row     = 0;
        rd_seen     = 0;
        res_cnt     = 0;
        stall_after = stall_at;
        stall_left  = 4;
        total_cols  = 32'(cols);
        total_rows  = 32'(rows);
    endtask

    task automatic push_reads(input int cols, input int rows);
        int chunks;
        chunks = (cols + NO_OF_UNITS - 1) / NO_OF_UNITS;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < chunks; c++) begin
                exp_mat.push_back(32'(r * chunks + c));
                exp_vec.push_back(32'(c));
                exp_last.push_back(c == chunks - 1);
            end
        end
    endtask

    task automatic run_pass(input int cols, input int rows, input int stall_at, input bit twice);
        int start_done;
        bit seen;
        setup_pass(cols, rows, stall_at);
        start_done = done_cnt;
        push_reads(cols, rows);
        for (int r = 0; r < rows; r++) begin
            exp_wa.push_back(32'(r));
            exp_wd.push_back(model_result(r, pass_tag));
        end
        @(negedge clk);
        start    = 1'b1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_on", 32'(busy), 32'd1);
        if (twice) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (done) seen = 1'b1;
        end
        check_val("done_timeout", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check_val("done_count", 32'(done_cnt - start_done), 32'd1);
        check_val("rd_left", 32'(exp_mat.size()), 32'd0);
        check_val("last_left", 32'(exp_last.size()), 32'd0);
        check_val("wr_left", 32'(exp_wa.size()), 32'd0);
        check_val("busy_off", 32'(busy), 32'd0);
`ifdef MXV_SEQ_PERF_EN
        check_val("perf_stalls", perf_stalls, (stall_at >= 0) ? 32'd4 : 32'd0);
        check_val("perf_cycles", perf_cycles, 32'(busy_cnt));
`endif
        stall_after = -1;
    endtask

    task automatic zero_pass(input int cols, input int rows);
        int start_done;
        setup_pass(cols, rows, -1);
        start_done = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("zero_busy", 32'(busy), 32'd1);
        check_val("zero_done_early", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_val("zero_done", 32'(done), 32'd1);
        check_val("zero_busy_off", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_val("zero_done_pulse", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        check_val("zero_done_count", 32'(done_cnt - start_done), 32'd1);
    endtask

    task automatic reset_abort();
        int start_done;
        bit reached;
        setup_pass(16, 3, -1);
        start_done = done_cnt;
        push_reads(16, 2);
        exp_wa.push_back(32'd0);
        exp_wd.push_back(model_result(0, pass_tag));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk);
            #2;
            if (rd_seen == 4) reached = 1'b1;
        end
        check_val("rst_reach", 32'(reached), 32'd1);
        @(posedge clk);
        #2;
        check_val("rst_in_wait", 32'(busy & ~mat_rd_en), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_rd", 32'({mat_rd_en, vec_rd_en}), 32'd0);
        check_val("rst_addr", 32'({mat_rd_addr, vec_rd_addr}), 32'd0);
        check_val("rst_dp", 32'({dp_in_valid, dp_in_last}), 32'd0);
        check_val("rst_ap_we", 32'(ap_we), 32'd0);
        check_val("rst_ap_addr", 32'(ap_addr), 32'd0);
        check_val("rst_ap_data", ap_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_no_done", 32'(done_cnt - start_done), 32'd0);
        check_val("rst_rd_left", 32'(exp_mat.size()), 32'd0);
        check_val("rst_wr_left", 32'(exp_wa.size()), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        total_cols      = 32'd0;
        total_rows      = 32'd0;
        dp_ready        = 1'b1;
        dp_result_valid = 1'b0;
        dp_result       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("init_busy", 32'(busy), 32'd0);
        check_val("init_done", 32'(done), 32'd0);
        check_val("init_rd", 32'({mat_rd_en, vec_rd_en}), 32'd0);
        check_val("init_addr", 32'({mat_rd_addr, vec_rd_addr}), 32'd0);
        check_val("init_dp", 32'({dp_in_valid, dp_in_last}), 32'd0);
        check_val("init_ap", 32'({ap_we, ap_addr}), 32'd0);
        check_val("init_ap_data", ap_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_pass(16, 2, -1, 1'b0);
        run_pass(20, 1, -1, 1'b0);
        run_pass(32, 1, 2, 1'b0);
        zero_pass(16, 0);
        zero_pass(0, 2);
        reset_abort();
        run_pass(16, 3, -1, 1'b0);
        run_pass(16, 2, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
